aes_inv_cipher: RTL and testbench



---
 rtl/aes_inv_cipher.sv | 186 ++++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: one inverse round per clock, plaintext 10 clocks after accept.
// Optional build macro AES_DEC_KEY_LATCH_EN: capture the key schedule at accept so w may change while busy.
module aes_inv_cipher (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [127:0]  i_ct,
    input  logic [1407:0] i_w,
    output logic          o_busy,
    output logic          o_done,
    output logic [127:0]  o_pt
);
    // state | meaning
    // IDLE  | waiting for start; accept loads ct ^ k10, rnd = 9
    // ROUND | full inverse round using k[rnd], rnd counts 9..1
    // FINAL | last round without InvMixColumns, xor k0, pulse done

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of b, 2b, 4b, 8b.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^ (c[0] ? b  : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
            o[119 - 32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
            o[111 - 32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
            o[103 - 32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
        end
        return o;
    endfunction

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_blk;
    logic [127:0]   r_pt;
    logic [3:0]     r_rnd;
    logic           r_done;
    logic [3:0]     w_ksel;
    logic [3:0]     w_kpos;
    logic [1407:0]  w_ksrc;
    logic [127:0]   w_rkey;
    logic [127:0]   w_rnd_out;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [1407:0]  r_w;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_w <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_w <= i_w;
        end
    end

    // The accept edge itself still needs k10 from the live bus.
    assign w_ksrc = (r_state == IDLE) ? i_w : r_w;
`else
    assign w_ksrc = i_w;
`endif

    always_comb begin
        w_ksel = r_rnd;
        if (r_state == IDLE) begin
            w_ksel = 4'd10;
        end else if (r_state == FINAL) begin
            w_ksel = 4'd0;
        end
    end

    assign w_kpos    = 4'd10 - w_ksel;
    assign w_rkey    = w_ksrc[{w_kpos, 7'd0} +: 128];
    assign w_rnd_out = inv_sub_bytes(inv_shift_rows(r_blk)) ^ w_rkey;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = ROUND;
            ROUND:   if (r_rnd == 4'd1) w_next = FINAL;
            FINAL:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_blk  <= '0;
            r_rnd  <= '0;
            r_pt   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_blk <= i_ct ^ w_rkey;
                        r_rnd <= 4'd9;
                    end
                end
                ROUND: begin
                    r_blk <= inv_mix_columns(w_rnd_out);
                    r_rnd <= r_rnd - 4'd1;
                end
                FINAL: begin
                    r_pt   <= w_rnd_out;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_pt   = r_pt;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors, start/reset corner cases, random loopback.
// Expected plaintexts and done cycles go into a scoreboard queue at stimulus time.
module tb_aes_inv_cipher;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic          i_clk   = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [127:0]  i_ct    = '0;
    logic [1407:0] i_w     = '0;
    logic          o_busy;
    logic          o_done;
    logic [127:0]  o_pt;

    aes_inv_cipher dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_ct    (i_ct),
        .i_w     (i_w),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_pt    (o_pt)
    );

    always #5 i_clk = ~i_clk;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           cyc;
        string        tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] sbox [256];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[8'(x)] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   wd [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] o;
        rc = 8'h01;
        o  = '0;
        for (int i = 0; i < 4; i++) wd[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            wd[i] = wd[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) o[1407 - 32*i -: 32] = wd[i];
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ks);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] s;
        s = pt ^ ks[1407 -: 128];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) a[i] = sbox[s[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) b[q + 4*c] = a[q + 4*((c + q) % 4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                    b[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
                    b[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
                    b[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
                    b[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = b[i];
            s = s ^ ks[1407 - 128*r -: 128];
        end
        return s;
    endfunction

    // Every done must match the oldest outstanding expectation, on its exact cycle.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n && o_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 128'(o_done), 128'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_pt"}, o_pt, e.pt);
                chk({e.tag, "_done_cycle"}, 128'(cyc), 128'(e.cyc));
                chk({e.tag, "_busy_low"}, 128'(o_busy), 128'd0);
            end
        end
    end

    // Call between edges; start is sampled at the next rising edge (T0).
    task automatic send(input logic [127:0] ct, input logic [1407:0] ks,
                        input logic [127:0] exp_pt, input string tag);
        exp_t e;
        i_ct    = ct;
        i_w     = ks;
        i_start = 1'b1;
        e.pt  = exp_pt;
        e.cyc = cyc + 11;
        e.tag = tag;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge i_clk);
        if (sb.size() != 0) begin
            chk("timeout_outstanding", 128'(sb.size()), 128'd0);
            sb.delete();
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [1407:0] ks_c1, ks_b, ks;
    logic [127:0]  key, p, c;

    initial begin
        build_sbox();
        ks_c1 = expand(KEY_C1);
        ks_b  = expand(KEY_B);

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", 128'(o_busy), 128'd0);
        chk("rst_done", 128'(o_done), 128'd0);
        chk("rst_pt", o_pt, 128'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        send(CT_C1, ks_c1, PT_C1, "c1");
        @(negedge i_clk);
        chk("c1_busy_high", 128'(o_busy), 128'd1);
        wait_idle();

        send(CT_B, ks_b, PT_B, "appb");
        wait_idle();

        // start held high: second accept lands in the done cycle of the first.
        begin
            exp_t e;
            i_ct    = CT_B;
            i_w     = ks_b;
            i_start = 1'b1;
            e.pt = PT_B; e.cyc = cyc + 11; e.tag = "b2b_first";
            sb.push_back(e);
            e.cyc = cyc + 22; e.tag = "b2b_second";
            sb.push_back(e);
            repeat (12) @(posedge i_clk);
            #1;
            i_start = 1'b0;
            wait_idle();
        end

        send(CT_C1, ks_c1, PT_C1, "ignored_start");
        repeat (2) @(posedge i_clk);
        #1;
        i_ct = CT_B;
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_idle();
        repeat (20) @(posedge i_clk);
        #1;
        i_ct = CT_C1;

        send(CT_C1, ks_c1, PT_C1, "aborted");
        repeat (4) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        sb.delete();
        @(posedge i_clk);
        @(negedge i_clk);
        chk("abort_busy", 128'(o_busy), 128'd0);
        chk("abort_done", 128'(o_done), 128'd0);
        chk("abort_pt", o_pt, 128'd0);
        i_rst_n = 1'b1;
        repeat (15) @(posedge i_clk);
        #1;
        send(CT_C1, ks_c1, PT_C1, "post_reset");
        wait_idle();

`ifdef AES_DEC_KEY_LATCH_EN
        send(CT_C1, ks_c1, PT_C1, "key_latch");
        @(posedge i_clk);
        #1;
        i_w = '0;
        wait_idle();
        i_w = ks_c1;
`endif

        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            p   = {$urandom, $urandom, $urandom, $urandom};
            ks  = expand(key);
            c   = encrypt(p, ks);
            send(c, ks, p, "loopback");
            repeat (10) @(posedge i_clk);
            #1;
        end
        wait_idle();
        repeat (3) @(posedge i_clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
